// File: rtl/systolic_seq_ctrl.sv
// Sequencer for one systolic matmul pass: LOAD A/B rows, COMPUTE window, DRAIN C rows, DONE pulse.
// Optional busy-cycle counter on perf_cycles is built when SEQ_PERF_CNT_EN is defined.
module systolic_seq_ctrl #(
  parameter int DIM     = 8,
  parameter int ROWBITS = $clog2(DIM),
  parameter int CNTBITS = $clog2(3*DIM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic               ld_valid,
  output logic               ld_ready,
  output logic               mem_WrEn,
  output logic [ROWBITS-1:0] mem_row,
  output logic               mem_en,
  output logic               sa_en,
  output logic [ROWBITS-1:0] sa_Crow,
  output logic               c_valid,
  input  logic               c_ready,
  output logic [31:0]        perf_cycles
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMP, S_DRAIN, S_DONE} state_t;

  localparam logic [ROWBITS-1:0] ROW_LAST = ROWBITS'(DIM-1);
  localparam logic [CNTBITS-1:0] CC_LAST  = CNTBITS'(3*DIM-3);

  state_t             r_state, w_nxt;
  logic [ROWBITS-1:0] r_ld, w_ld, r_dr, w_dr;
  logic [CNTBITS-1:0] r_cc, w_cc;
  logic               r_busy, r_done, r_ld_ready, r_en, r_c_valid;
  logic               w_ld_acc, w_c_acc;

  assign w_ld_acc = ld_valid & r_ld_ready;
  assign w_c_acc  = c_ready & r_c_valid;

  always_comb begin
    w_nxt = r_state;
    w_ld  = r_ld;
    w_cc  = r_cc;
    w_dr  = r_dr;
    case (r_state)
      S_IDLE: if (start) begin
        w_nxt = S_LOAD;
        w_ld  = '0;
      end
      S_LOAD: if (w_ld_acc) begin
        if (r_ld == ROW_LAST) begin
          w_nxt = S_COMP;
          w_cc  = '0;
        end else begin
          w_ld = r_ld + 1'b1;
        end
      end
      S_COMP: begin
        if (r_cc == CC_LAST) begin
          w_nxt = S_DRAIN;
          w_dr  = '0;
        end else begin
          w_cc = r_cc + 1'b1;
        end
      end
      S_DRAIN: if (w_c_acc) begin
        if (r_dr == ROW_LAST) w_nxt = S_DONE;
        else                  w_dr  = r_dr + 1'b1;
      end
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the state being entered so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ld       <= '0;
      r_cc       <= '0;
      r_dr       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ld_ready <= 1'b0;
      r_en       <= 1'b0;
      r_c_valid  <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_ld       <= w_ld;
      r_cc       <= w_cc;
      r_dr       <= w_dr;
      r_busy     <= (w_nxt != S_IDLE);
      r_done     <= (w_nxt == S_DONE);
      r_ld_ready <= (w_nxt == S_LOAD);
      r_en       <= (w_nxt == S_COMP);
      r_c_valid  <= (w_nxt == S_DRAIN);
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign ld_ready = r_ld_ready;
  assign mem_WrEn = w_ld_acc;
  assign mem_row  = r_ld;
  assign mem_en   = r_en;
  assign sa_en    = r_en;
  assign sa_Crow  = r_dr;
  assign c_valid  = r_c_valid;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] r_perf;

  // The accepting start cycle is the first cycle of the pass, so the count restarts at 1.
  always_ff @(posedge clk) begin
    if (rst)                                     r_perf <= '0;
    else if (r_state == S_IDLE && start)         r_perf <= 32'd1;
    else if (r_busy && r_perf != 32'hFFFF_FFFF)  r_perf <= r_perf + 32'd1;
  end

  assign perf_cycles = r_perf;
`else
  assign perf_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl (DIM=8): phase-count model checked every cycle,
// plus literal latency / count expectations per scenario.
module tb_systolic_seq_ctrl;
  localparam int DIM = 8;
  localparam int RB  = $clog2(DIM);

  logic          clk = 1'b0;
  logic          rst, start, ld_valid, c_ready;
  logic          busy, done, ld_ready, mem_WrEn, mem_en, sa_en, c_valid;
  logic [RB-1:0] mem_row, sa_Crow;
  logic [31:0]   perf_cycles;

  always #5 clk = ~clk;

  systolic_seq_ctrl #(.DIM(DIM)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .mem_WrEn(mem_WrEn), .mem_row(mem_row),
    .mem_en(mem_en), .sa_en(sa_en), .sa_Crow(sa_Crow), .c_valid(c_valid),
    .c_ready(c_ready), .perf_cycles(perf_cycles)
  );

  int ncmp = 0, nbad = 0;
  int cyc = 0;
  bit cmp_en = 0;
  bit tog = 0;
  int stall_left = 0;
  int wren_cnt = 0, saen_cnt = 0, ldr_cnt = 0, done_cnt = 0, done_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: phase 0 idle, 1 load, 2 compute, 3 drain, 4 done; n = items finished in phase.
  int ph = 0, n = 0;
  logic [31:0] pm = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      ph <= 0; n <= 0; pm <= 0;
    end else begin
      if (ph != 0) pm <= pm + 1;
      case (ph)
        0: if (start) begin ph <= 1; n <= 0; pm <= 1; end
        1: if (n + int'(ld_valid) == DIM) begin ph <= 2; n <= 0; end
           else n <= n + int'(ld_valid);
        2: if (n + 1 == 3*DIM-2) begin ph <= 3; n <= 0; end
           else n <= n + 1;
        3: if (n + int'(c_ready) == DIM) ph <= 4;
           else n <= n + int'(c_ready);
        default: ph <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy",     busy,     32'(ph != 0));
      chk("done",     done,     32'(ph == 4));
      chk("ld_ready", ld_ready, 32'(ph == 1));
      chk("mem_WrEn", mem_WrEn, 32'(ph == 1 && ld_valid));
      chk("mem_en",   mem_en,   32'(ph == 2));
      chk("sa_en",    sa_en,    32'(ph == 2));
      chk("c_valid",  c_valid,  32'(ph == 3));
      if (ph == 1) chk("mem_row", 32'(mem_row), 32'(n));
      if (ph == 3) chk("sa_Crow", 32'(sa_Crow), 32'(n));
`ifdef SEQ_PERF_CNT_EN
      chk("perf_cycles", perf_cycles, pm);
`else
      chk("perf_cycles", perf_cycles, 32'h0);
`endif
    end
    if (mem_WrEn === 1'b1) wren_cnt++;
    if (sa_en    === 1'b1) saen_cnt++;
    if (ld_ready === 1'b1) ldr_cnt++;
    if (done     === 1'b1) begin done_cnt++; done_cyc = cyc; end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (tog) ld_valid = ~ld_valid;
    if (stall_left > 0 && c_valid && sa_Crow == RB'(4)) begin
      c_ready = 1'b0;
      stall_left--;
    end else begin
      c_ready = 1'b1;
    end
  endtask

  task automatic wait_done(input int d0, input string nm);
    int k = 0;
    while (done_cnt == d0 && k < 300) begin tick(); k++; end
    if (done_cnt == d0) begin
      ncmp++; nbad++;
      $display("FAIL %s: done timeout got none expected pulse", nm);
    end
  endtask

  task automatic wait_sig(input bit want_sa, input string nm);
    int k = 0;
    while (k < 100 && !(want_sa ? sa_en : c_valid)) begin tick(); k++; end
    chk(nm, 32'(want_sa ? sa_en : c_valid), 32'd1);
  endtask

  // Launch one pass and check latency (start-edge to done) and per-phase counts.
  task automatic run_pass(input string nm, input int exp_lat, input int exp_ldr);
    int w0, s0, l0, d0, t0;
    w0 = wren_cnt; s0 = saen_cnt; l0 = ldr_cnt; d0 = done_cnt; t0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(d0, nm);
    chk({nm, "_latency"},  32'(done_cyc + 1 - t0), 32'(exp_lat));
    chk({nm, "_wren"},     32'(wren_cnt - w0),     32'd8);
    chk({nm, "_sa_en"},    32'(saen_cnt - s0),     32'd22);
    chk({nm, "_ld_ready"}, 32'(ldr_cnt - l0),      32'(exp_ldr));
    chk({nm, "_done_cnt"}, 32'(done_cnt - d0),     32'd1);
    tick();
    chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
`ifdef SEQ_PERF_CNT_EN
    chk({nm, "_perf"}, perf_cycles, 32'(exp_lat));
`else
    chk({nm, "_perf"}, perf_cycles, 32'h0);
`endif
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; ld_valid = 1'b1; c_ready = 1'b1;
    tick(); tick();
    cmp_en = 1;
    chk("rst_busy",    32'(busy),     32'd0);
    chk("rst_done",    32'(done),     32'd0);
    chk("rst_ldrdy",   32'(ld_ready), 32'd0);
    chk("rst_wren",    32'(mem_WrEn), 32'd0);
    chk("rst_sa_en",   32'(sa_en),    32'd0);
    chk("rst_cvalid",  32'(c_valid),  32'd0);
    chk("rst_mem_row", 32'(mem_row),  32'd0);
    chk("rst_sa_crow", 32'(sa_Crow),  32'd0);
    chk("rst_perf",    perf_cycles,   32'd0);
    rst = 1'b0;
    tick();

    run_pass("basic", 40, 8);

    // ld_valid alternates, low in the first LOAD cycle
    ld_valid = 1'b1; tog = 1;
    run_pass("ld_toggle", 48, 16);
    tog = 0; ld_valid = 1'b1;
    tick();

    stall_left = 3;
    run_pass("c_stall", 43, 8);
    tick();

    // start pulses in COMPUTE and DRAIN must be dropped
    d0 = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    wait_sig(1'b1, "ign_reach_comp");
    start = 1'b1; tick(); start = 1'b0;
    wait_sig(1'b0, "ign_reach_drain");
    start = 1'b1; tick(); start = 1'b0;
    wait_done(d0, "ignore_start");
    repeat (4) tick();
    chk("ignore_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("ignore_busy",     32'(busy),          32'd0);

    // reset at compute counter 10
    start = 1'b1; tick(); start = 1'b0;
    wait_sig(1'b1, "rst_reach_comp");
    repeat (10) tick();
    chk("pre_rst_sa_en", 32'(sa_en), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort_busy",   32'(busy),   32'd0);
    chk("abort_sa_en",  32'(sa_en),  32'd0);
    chk("abort_mem_en", 32'(mem_en), 32'd0);
    tick();
    run_pass("after_rst", 40, 8);
    run_pass("second", 40, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
